// File: rtl/peak_finder_pkg.sv
// Shared constants and FSM encoding for the histogram peak finder.
//   Nb      : default bin index width (histogram depth is 2**Nb bins)
//   CountW  : default histogram count width
//   pfState_e : scan FSM states
package peak_finder_pkg;

  localparam int unsigned Nb     = 4;
  localparam int unsigned CountW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pfState_e;

endpackage

// File: rtl/peak_finder.sv
// Histogram peak finder: on start, reads every bin of an external histogram
// RAM once, tracks the largest count (lowest index wins ties) and reports
// its index.
//   clk       : clock, rising edge
//   res       : asynchronous active-low reset
//   start     : one-cycle scan request (ignored unless idle)
//   binAddr   : RAM read address
//   binRdEn   : RAM read enable
//   binCount  : RAM read data, RD_LAT cycles after binRdEn
//   busy      : scan in progress
//   peakCH    : index of the maximum bin (held until the next scan ends)
//   peakDone  : one-cycle strobe, peakCH/peakValid valid with it
//   peakValid : maximum count was nonzero
module peak_finder
  import peak_finder_pkg::*;
#(
  parameter int unsigned NB     = Nb,
  parameter int unsigned CW     = CountW,
  // Only 1 is supported: DRAIN is a single cycle wide.
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  output logic [NB-1:0] binAddr,
  output logic          binRdEn,
  input  logic [CW-1:0] binCount,
  output logic          busy,
  output logic [NB-1:0] peakCH,
  output logic          peakDone,
  output logic          peakValid
);

  pfState_e state, nextState;

  logic [CW-1:0] maxCount;
  logic [NB-1:0] maxIdx;

  // Read-valid flag and address delayed to line up with returned data.
  logic          rdValid [RD_LAT];
  logic [NB-1:0] rdIdx   [RD_LAT];

  logic          hit;
  logic [CW-1:0] candCount;
  logic [NB-1:0] candIdx;
  logic          accept;
  logic          lastAddr;

  assign accept   = (state == IDLE) && start;
  assign lastAddr = (binAddr == '1);

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = SCAN;
      SCAN:    if (lastAddr) nextState = DRAIN;
      DRAIN:   nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Strict compare keeps the earliest (lowest) index on ties.
  always_comb begin
    hit       = rdValid[RD_LAT-1] && (binCount > maxCount);
    candCount = hit ? binCount : maxCount;
    candIdx   = hit ? rdIdx[RD_LAT-1] : maxIdx;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        rdValid[i] <= 1'b0;
        rdIdx[i]   <= '0;
      end
    end else begin
      rdValid[0] <= binRdEn;
      rdIdx[0]   <= binAddr;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rdValid[i] <= rdValid[i-1];
        rdIdx[i]   <= rdIdx[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      binAddr   <= '0;
      binRdEn   <= 1'b0;
      busy      <= 1'b0;
      maxCount  <= '0;
      maxIdx    <= '0;
      peakCH    <= '0;
      peakDone  <= 1'b0;
      peakValid <= 1'b0;
    end else begin
      busy     <= (nextState != IDLE);
      peakDone <= 1'b0;

      if (accept) begin
        binAddr  <= '0;
        binRdEn  <= 1'b1;
        maxCount <= '0;
        maxIdx   <= '0;
      end else begin
        maxCount <= candCount;
        maxIdx   <= candIdx;
      end

      // Address parks on the last bin rather than wrapping.
      if (state == SCAN) begin
        if (lastAddr) binRdEn <= 1'b0;
        else          binAddr <= binAddr + NB'(1);
      end

      // The final bin's data arrives during DRAIN, so results are taken
      // from the live compare rather than the running registers.
      if (state == DRAIN) begin
        peakCH    <= candIdx;
        peakValid <= (candCount != '0);
        peakDone  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_peak_finder.sv
// Directed bench for peak_finder (NB=4, CW=8) with a behavioural
// single-cycle-latency histogram RAM.
module tb_peak_finder;

  localparam int unsigned NB = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          res;
  logic          start;
  logic [NB-1:0] binAddr;
  logic          binRdEn;
  logic [CW-1:0] binCount;
  logic          busy;
  logic [NB-1:0] peakCH;
  logic          peakDone;
  logic          peakValid;

  logic [CW-1:0] mem [16];
  logic          busyLog [64];

  int checkCnt = 0;
  int errCnt   = 0;

  int            d1, d2, dCnt, rdCnt, busyHigh;
  logic [NB-1:0] chAtDone;

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (binRdEn) binCount <= mem[binAddr];

  peak_finder #(.NB(NB), .CW(CW), .RD_LAT(1)) dut (
    .clk      (clk),
    .res      (res),
    .start    (start),
    .binAddr  (binAddr),
    .binRdEn  (binRdEn),
    .binCount (binCount),
    .busy     (busy),
    .peakCH   (peakCH),
    .peakDone (peakDone),
    .peakValid(peakValid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fillMem(input logic [CW-1:0] val);
    for (int i = 0; i < 16; i++) mem[i] = val;
  endtask

  // Cycle c of the loop is the clock period whose closing edge samples
  // mask[c]; outputs are observed 1 time unit into that period.
  task automatic runCycles(input logic [63:0] mask, input int n,
                           output int first, output int second, output int doneN,
                           output int rdN, output logic [NB-1:0] chFirst);
    first = -1; second = -1; doneN = 0; rdN = 0; chFirst = '0;
    for (int c = 0; c < n; c++) begin
      start      = mask[c];
      busyLog[c] = busy;
      if (peakDone) begin
        doneN++;
        if (first < 0) begin
          first   = c;
          chFirst = peakCH;
        end else if (second < 0) begin
          second = c;
        end
      end
      if (binRdEn) rdN++;
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    res   = 1'b0;
    start = 1'b0;
    fillMem('0);
    tick();
    tick();
    chk("rst_peakCH",    peakCH,    0);
    chk("rst_peakValid", peakValid, 0);
    chk("rst_peakDone",  peakDone,  0);
    chk("rst_busy",      busy,      0);
    chk("rst_binRdEn",   binRdEn,   0);
    chk("rst_binAddr",   binAddr,   0);
    res = 1'b1;
    tick();

    // Single peak at bin 9.
    fillMem('0);
    mem[9] = 8'd200;
    runCycles(64'h1, 30, d1, d2, dCnt, rdCnt, chAtDone);
    chk("s9_doneCycle", d1, 18);
    chk("s9_doneCnt",   dCnt, 1);
    chk("s9_chAtDone",  chAtDone, 9);
    chk("s9_peakCH",    peakCH, 9);
    chk("s9_peakValid", peakValid, 1);
    chk("s9_rdCnt",     rdCnt, 16);
    chk("s9_busy0",     busyLog[0], 0);
    chk("s9_busy1",     busyLog[1], 1);
    chk("s9_busy18",    busyLog[18], 1);
    chk("s9_busy19",    busyLog[19], 0);

    // Tie between bins 3 and 12.
    fillMem(8'd10);
    mem[3]  = 8'd50;
    mem[12] = 8'd50;
    runCycles(64'h1, 25, d1, d2, dCnt, rdCnt, chAtDone);
    chk("tie_doneCycle", d1, 18);
    chk("tie_peakCH",    peakCH, 3);
    chk("tie_peakValid", peakValid, 1);

    // Maximum in the last bin, near-full-scale counts.
    fillMem(8'd254);
    mem[15] = 8'd255;
    runCycles(64'h1, 25, d1, d2, dCnt, rdCnt, chAtDone);
    chk("last_peakCH", chAtDone, 15);
    chk("last_hold",   peakCH, 15);
    chk("last_rdCnt",  rdCnt, 16);
    chk("last_addr",   binAddr, 15);

    // Empty histogram.
    fillMem('0);
    runCycles(64'h1, 25, d1, d2, dCnt, rdCnt, chAtDone);
    chk("zero_peakCH",    peakCH, 0);
    chk("zero_peakValid", peakValid, 0);
    chk("zero_doneCnt",   dCnt, 1);
    chk("zero_doneCycle", d1, 18);

    // Starts at 5 and 17 dropped, start at 19 accepted.
    fillMem('0);
    mem[9] = 8'd200;
    runCycles((64'h1 << 0) | (64'h1 << 5) | (64'h1 << 17) | (64'h1 << 19), 45,
              d1, d2, dCnt, rdCnt, chAtDone);
    chk("b2b_first",   d1, 18);
    chk("b2b_second",  d2, 37);
    chk("b2b_doneCnt", dCnt, 2);
    chk("b2b_rdCnt",   rdCnt, 32);
    chk("b2b_peakCH",  peakCH, 9);

    // Reset mid-scan.
    runCycles(64'h1, 8, d1, d2, dCnt, rdCnt, chAtDone);
    chk("pre_busy", busy, 1);
    res = 1'b0;
    #1;
    chk("mid_peakCH",    peakCH, 0);
    chk("mid_peakValid", peakValid, 0);
    chk("mid_busy",      busy, 0);
    chk("mid_binRdEn",   binRdEn, 0);
    chk("mid_binAddr",   binAddr, 0);
    chk("mid_peakDone",  peakDone, 0);
    tick();
    tick();
    res = 1'b1;
    runCycles(64'h0, 25, d1, d2, dCnt, rdCnt, chAtDone);
    busyHigh = 0;
    for (int i = 0; i < 25; i++) if (busyLog[i]) busyHigh++;
    chk("post_noDone", dCnt, 0);
    chk("post_noBusy", busyHigh, 0);
    chk("post_noRead", rdCnt, 0);
    runCycles(64'h1, 22, d1, d2, dCnt, rdCnt, chAtDone);
    chk("fresh_doneCycle", d1, 18);
    chk("fresh_peakCH",    peakCH, 9);
    chk("fresh_peakValid", peakValid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
